// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte stream and IMEM write bundle for the boot loader
interface imem_boot_loader_if #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32
);
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  imem_wr_en;
  logic [PC_WIDTH-1:0]   imem_wr_addr;
  logic [INST_WIDTH-1:0] imem_wr_data;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_wr_en, imem_wr_addr, imem_wr_data
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_wr_en, imem_wr_addr, imem_wr_data
  );
endinterface

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - packs a byte stream into IMEM words and releases the core
module imem_boot_loader #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32,
  parameter int MAX_WORDS  = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [PC_WIDTH-1:0] load_len,
  imem_boot_loader_if.slave   bus,
  output logic                core_run,
  output logic                core_flush,
  output logic                busy,
  output logic                done,
  output logic                err_len
);
  localparam logic [PC_WIDTH-1:0] MAX_LEN = PC_WIDTH'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_RELEASE, S_RUN
  } state_t;

  state_t                state, next;
  logic [PC_WIDTH-1:0]   len_q;
  logic [PC_WIDTH-1:0]   word_cnt;
  logic [1:0]            byte_cnt;
  logic [INST_WIDTH-1:0] asm_q;
  logic                  cmd;
  logic                  len_ok;
  logic                  accept;

  assign bus.byte_ready = (state == S_LOAD);
  assign cmd    = start && (state == S_IDLE || state == S_RUN);
  assign len_ok = (load_len != '0) && (load_len <= MAX_LEN);
  assign accept = (state == S_LOAD) && bus.byte_valid;

  always_comb begin
    next = state;
    case (state)
      S_IDLE, S_RUN: begin
        if (start) begin
          if (load_len == '0) next = S_RELEASE;
          else if (len_ok)    next = S_LOAD;
          else                next = S_IDLE;
        end
      end
      S_LOAD:    if (accept && byte_cnt == 2'd3) next = S_WRITE;
      S_WRITE:   next = (word_cnt + PC_WIDTH'(1) == len_q) ? S_RELEASE : S_LOAD;
      S_RELEASE: next = S_RUN;
      default:   next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      len_q            <= '0;
      word_cnt         <= '0;
      byte_cnt         <= '0;
      asm_q            <= '0;
      err_len          <= 1'b0;
      core_run         <= 1'b0;
      core_flush       <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      bus.imem_wr_en   <= 1'b0;
      bus.imem_wr_addr <= '0;
      bus.imem_wr_data <= '0;
    end else begin
      state          <= next;
      core_run       <= (next == S_RUN);
      done           <= (next == S_RUN);
      core_flush     <= (next == S_RELEASE);
      busy           <= (next == S_LOAD) || (next == S_WRITE);
      bus.imem_wr_en <= (next == S_WRITE);

      if (cmd) begin
        if (len_ok) begin
          len_q    <= load_len;
          word_cnt <= '0;
          byte_cnt <= '0;
          err_len  <= 1'b0;
        end else if (load_len != '0) begin
          err_len  <= 1'b1;
        end
      end

      if (accept) begin
        asm_q[{byte_cnt, 3'b000} +: 8] <= bus.byte_data;
        byte_cnt <= byte_cnt + 2'd1;
      end

      // The fourth byte bypasses the assembly register straight into the write data.
      if (accept && byte_cnt == 2'd3) begin
        bus.imem_wr_addr <= word_cnt << 2;
        bus.imem_wr_data <= {bus.byte_data, asm_q[23:0]};
      end

      if (state == S_WRITE) word_cnt <= word_cnt + PC_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - scoreboard bench for imem_boot_loader
module tb_imem_boot_loader;
  localparam int PW  = 32;
  localparam int MAXW = 1024;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] load_len = '0;
  logic          core_run, core_flush, busy, done, err_len;

  imem_boot_loader_if #(.PC_WIDTH(PW), .INST_WIDTH(32)) bus ();

  imem_boot_loader #(.PC_WIDTH(PW), .INST_WIDTH(32), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .load_len(load_len), .bus(bus),
    .core_run(core_run), .core_flush(core_flush), .busy(busy), .done(done), .err_len(err_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int flush_cnt = 0;
  logic [7:0]  tx_q[$];
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: word w is bytes 4w..4w+3 little-endian, written at byte address 4w.
  task automatic push_expected(input int nwords);
    for (int w = 0; w < nwords; w++) begin
      logic [31:0] d;
      d = {tx_q[4*w+3], tx_q[4*w+2], tx_q[4*w+1], tx_q[4*w]};
      exp_q.push_back({32'(w * 4), d});
    end
  endtask

  always @(negedge clk) begin
    if (bus.imem_wr_en) begin
      wr_cnt++;
      check("ready_low_in_write", {63'd0, bus.byte_ready}, 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {32'd0, bus.imem_wr_addr}, {32'd0, e[63:32]});
        check("wr_data", {32'd0, bus.imem_wr_data}, {32'd0, e[31:0]});
      end
    end
    if (core_flush) begin
      flush_cnt++;
      check("run_low_in_flush", {63'd0, core_run}, 64'd0);
    end
  end

  task automatic pulse_start(input logic [PW-1:0] len);
    @(negedge clk);
    start = 1'b1;
    load_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: valid held high, 1: toggling, 2: random
  task automatic send_bytes(input int n, input int mode);
    int idx = 0;
    int guard = 0;
    logic v;
    logic tog = 1'b1;
    while (idx < n && guard < 4000) begin
      @(negedge clk);
      v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      bus.byte_valid = v;
      bus.byte_data = tx_q[idx];
      if (v && bus.byte_ready) idx++;
      guard++;
    end
    if (idx < n) check("byte_timeout", 64'(idx), 64'(n));
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_run();
    int guard = 0;
    while (!core_run && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check("run_reached", {63'd0, core_run}, 64'd1);
    check("done_in_run", {63'd0, done}, 64'd1);
    check("busy_in_run", {63'd0, busy}, 64'd0);
  endtask

  task automatic run_load(input int len, input int mode, input bit keep_bytes);
    int wr_base, fl_base;
    if (!keep_bytes) begin
      tx_q.delete();
      for (int i = 0; i < len * 4; i++) tx_q.push_back(8'($urandom));
    end
    wr_base = wr_cnt;
    fl_base = flush_cnt;
    push_expected(len);
    pulse_start(PW'(len));
    check("run_low_after_start", {63'd0, core_run}, 64'd0);
    send_bytes(len * 4, mode);
    wait_run();
    check("write_count", 64'(wr_cnt - wr_base), 64'(len));
    check("flush_count", 64'(flush_cnt - fl_base), 64'd1);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_run"}, {63'd0, core_run}, 64'd0);
    check({tag, "_flush"}, {63'd0, core_flush}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_err"}, {63'd0, err_len}, 64'd0);
    check({tag, "_wr_en"}, {63'd0, bus.imem_wr_en}, 64'd0);
    check({tag, "_ready"}, {63'd0, bus.byte_ready}, 64'd0);
    check({tag, "_addr"}, {32'd0, bus.imem_wr_addr}, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.byte_valid = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int wr_base, fl_base;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    do_reset();

    tx_q = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    check("model_word0", {32'd0, tx_q[3], tx_q[2], tx_q[1], tx_q[0]}, 64'h0000_0513);
    run_load(2, 0, 1'b1);
    run_load(2, 1, 1'b1);
    for (int r = 0; r < 4; r++) run_load(int'($urandom_range(1, 6)), 2, 1'b0);

    // Zero-length start releases immediately.
    do_reset();
    wr_base = wr_cnt;
    fl_base = flush_cnt;
    pulse_start('0);
    check("zero_len_flush", {63'd0, core_flush}, 64'd1);
    @(negedge clk);
    check("zero_len_run", {63'd0, core_run}, 64'd1);
    check("zero_len_writes", 64'(wr_cnt - wr_base), 64'd0);

    // Oversize length is rejected and sticky until a legal start.
    do_reset();
    pulse_start(PW'(MAXW + 1));
    check("oversize_err", {63'd0, err_len}, 64'd1);
    check("oversize_run", {63'd0, core_run}, 64'd0);
    check("oversize_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("oversize_ready", {63'd0, bus.byte_ready}, 64'd0);
    tx_q.delete();
    for (int i = 0; i < 4; i++) tx_q.push_back(8'($urandom));
    push_expected(1);
    pulse_start(PW'(1));
    check("legal_clears_err", {63'd0, err_len}, 64'd0);
    check("legal_busy", {63'd0, busy}, 64'd1);
    send_bytes(4, 0);
    wait_run();

    // Reset after 6 bytes of a 3-word load leaves exactly one write.
    do_reset();
    tx_q.delete();
    for (int i = 0; i < 12; i++) tx_q.push_back(8'($urandom));
    wr_base = wr_cnt;
    push_expected(1);
    pulse_start(PW'(3));
    send_bytes(6, 0);
    reset_n = 1'b0;
    @(negedge clk);
    check_all_zero("midload");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midload_writes", 64'(wr_cnt - wr_base), 64'd1);
    check("midload_scoreboard", 64'(exp_q.size()), 64'd0);
    run_load(1, 2, 1'b0);

    // Reprogram from RUN.
    check("in_run_before_reprog", {63'd0, core_run}, 64'd1);
    run_load(1, 0, 1'b0);
    run_load(3, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
